rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter sharing one resource among 16 requesters.
- Selects the winner with a rotating-priority encoder search and holds the grant until the owner releases it or a hold-limit timer expires.
- Inserts one turnaround cycle between owners.
- Sits in front of a shared bus or encoder datapath; consumers decode grant_id or use grant_vec directly.

Parameters:
- NUM_REQ, 16, number of requesters (fixed at 16 for this revision; ID_W = 4).
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant (legal range 1..255).
- HOLD_W, 8, width of the hold counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  arbitration enable; when low, no new grant is issued.
- req  input  16  request vector, one bit per requester, level-sensitive.
- grant_vec  output  16  one-hot grant, registered.
- grant_id  output  4  binary index of current owner, registered.
- grant_valid  output  1  high while a grant is held.
- preempt  output  1  one-cycle pulse when a grant ends by MAX_HOLD timeout.

Behaviour:
- Reset (async assert, sync-to-clk deassert is the integrator's job): state=IDLE, grant_vec=0, grant_id=0, grant_valid=0, preempt=0, hold_cnt=0, rr_ptr=0.
- States are IDLE, OWN, TURN.
- IDLE:
  - If enable=1 and req!=0, pick winner = the first set req bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1 .. 15, 0 .. rr_ptr-1).
  - Register grant_vec=1<<winner, grant_id=winner, grant_valid=1, hold_cnt=1; go to OWN.
  - Latency is 1 cycle from req sampled to grant_valid high.
- OWN:
  - Release when req[grant_id]=0 (normal release) or hold_cnt==MAX_HOLD (timeout).
  - On either release: clear grant_vec/grant_valid, set rr_ptr=grant_id+1 (mod 16, 15 wraps to 0), go to TURN.
  - On timeout: preempt=1 for exactly the cycle grant_valid falls.
  - Otherwise hold_cnt increments by 1 and saturates at MAX_HOLD.
  - enable going low during OWN does not revoke the current grant; it only blocks the next one.
  - If release and timeout occur in the same cycle, release wins: preempt=0.
- TURN:
  - Exactly one dead cycle with grant_valid=0; go to IDLE.
  - Back-to-back owners therefore see grant gaps of 2 cycles minimum (TURN plus IDLE evaluation).
- Fairness: after owner k, requester k has lowest priority. Any continuously requesting line is granted within 15 intervening grants.
- Output invariants:
  - grant_vec is one-hot or zero.
  - grant_vec is zero exactly when grant_valid is 0.
  - grant_id holds its last value while grant_valid=0.
- Requests that drop while pending are simply not considered; there is no latching of requests.
- Reset mid-grant: outputs clear asynchronously in the same cycle and rr_ptr returns to 0.
- MAX_HOLD=1: every grant lasts one cycle and ends with preempt=1 unless req falls simultaneously.

Decomposition:
- Shared package rr_arb_pkg:
  - NUM_REQ=16 and ID_W=4.
  - State enum IDLE/OWN/TURN (2-bit encoding).
  - Function onehot_of(id).
- Sub-module rr_pri_search (combinational):
  - Inputs are req[15:0] and ptr[3:0]; outputs are found, idx[3:0].
  - Rotates req right by ptr, applies a fixed lowest-index priority encoder, then adds ptr back mod 16.
- The arbiter top holds the FSM, hold counter and pointer registers.

Test Plan:
- Reset then req=16'h0001, enable=1: grant_valid rises next cycle, grant_id=0, grant_vec=16'h0001. Drop req: grant clears next cycle, then TURN, rr_ptr=1.
- req=16'hFFFF held constant with MAX_HOLD=8:
  - Grants rotate 0,1,2..15,0.
  - Each grant lasts 8 cycles and ends with a preempt pulse.
  - There are 2 idle cycles between grants.
- rr_ptr=5 (after owner 4), req=16'h0011: next grant goes to id 0 (wrap); the following grant goes to id 4.
- Release and timeout in the same cycle (req[id] falls when hold_cnt=MAX_HOLD): grant ends, preempt=0.
- enable=0 during OWN with req=16'h0300: the current owner 8 keeps its grant until release. After TURN no new grant is issued; raising enable gives grant_id=9.
- Assert reset asynchronously mid-OWN (grant_id=7): grant_vec=0, grant_valid=0 with no clock edge; after release from reset with req=16'h0080, grant_id=7 (rr_ptr=0 search).

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 16-way round-robin grant arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 16;
    localparam int unsigned ID_W    = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn  = 2'd1,
        StTurn = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] onehot_of(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_pri_search.sv
// Rotating-priority search: first set request at or above ptr, wrapping past 15 to 0.
module rr_pri_search
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W-1:0]      enc;

    // Doubling the vector turns the rotate into a plain shift.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        enc = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = ID_W'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = enc + ptr;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter: holds a grant until release or hold-limit timeout,
// then inserts one turnaround cycle before the next owner.
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant_vec,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid,
    output logic               preempt
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_vec_q, grant_vec_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               grant_valid_q, grant_valid_d;
    logic               preempt_q, preempt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic               found;
    logic [ID_W-1:0]    win_idx;
    logic               timeout;
    logic               owner_req;

    rr_pri_search u_search (
        .req   (req),
        .ptr   (rr_ptr_q),
        .found (found),
        .idx   (win_idx)
    );

    assign timeout   = (hold_cnt_q == HOLD_W'(MAX_HOLD));
    assign owner_req = req[grant_id_q];

    always_comb begin
        state_d       = state_q;
        grant_vec_d   = grant_vec_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        preempt_d     = 1'b0;
        hold_cnt_d    = hold_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (enable && found) begin
                    grant_vec_d   = onehot_of(win_idx);
                    grant_id_d    = win_idx;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = HOLD_W'(1);
                    state_d       = StOwn;
                end
            end
            StOwn: begin
                if (!owner_req || timeout) begin
                    grant_vec_d   = '0;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = grant_id_q + ID_W'(1);
                    // A simultaneous release takes precedence over the timeout.
                    preempt_d     = owner_req;
                    state_d       = StTurn;
                end else if (!timeout) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            StTurn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            grant_vec_q   <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            preempt_q     <= 1'b0;
            hold_cnt_q    <= '0;
            rr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_vec_q   <= grant_vec_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            preempt_q     <= preempt_d;
            hold_cnt_q    <= hold_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign grant_vec   = grant_vec_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_rr_grant_arbiter;

    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] req;
    logic [15:0] grant_vec;
    logic [3:0]  grant_id;
    logic        grant_valid;
    logic        preempt;

    int checks   = 0;
    int failures = 0;

    rr_grant_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req         (req),
        .grant_vec   (grant_vec),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the resource, for how long, and whose turn is next.
    bit m_busy    = 0;
    int m_owner   = 0;
    int m_held    = 0;
    int m_ptr     = 0;
    bit m_dead    = 0;
    bit m_pre     = 0;
    int m_last_id = 0;
    int m_w;
    bit m_f;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_owner = 0; m_held = 0; m_ptr = 0;
            m_dead = 0; m_pre = 0; m_last_id = 0;
        end else begin
            m_pre = 0;
            if (m_busy) begin
                if (!req[m_owner] || m_held == MAX_HOLD) begin
                    m_pre  = req[m_owner];
                    m_busy = 0;
                    m_dead = 1;
                    m_ptr  = (m_owner + 1) % 16;
                end else begin
                    m_held = m_held + 1;
                end
            end else if (m_dead) begin
                m_dead = 0;
            end else if (enable && req != 16'h0) begin
                m_f = 0;
                m_w = 0;
                for (int k = 0; k < 16; k++) begin
                    if (!m_f && req[(m_ptr + k) % 16]) begin
                        m_f = 1;
                        m_w = (m_ptr + k) % 16;
                    end
                end
                m_busy    = 1;
                m_owner   = m_w;
                m_last_id = m_w;
                m_held    = 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        req    = 16'h0;
        enable = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        req    = 16'h0;
        tick();
        tick();
        checks += 4;
        if (grant_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b want=0", grant_valid);
        end
        if (grant_vec !== 16'h0) begin
            failures++; $display("FAIL reset_vec got=%h want=0000", grant_vec);
        end
        if (grant_id !== 4'h0) begin
            failures++; $display("FAIL reset_id got=%0d want=0", grant_id);
        end
        if (preempt !== 1'b0) begin
            failures++; $display("FAIL reset_preempt got=%b want=0", preempt);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        enable = 1'b1;
        req    = 16'h0001;
        tick();
        checks++;
        if ({grant_valid, grant_id, grant_vec} !== {1'b1, 4'd0, 16'h0001}) begin
            failures++;
            $display("FAIL single_grant got=%b/%0d/%h want=1/0/0001", grant_valid, grant_id,
                     grant_vec);
        end
        req = 16'h0;
        tick();
        checks++;
        if ({grant_valid, grant_id, grant_vec, preempt} !== {1'b1 ^ 1'b1, 4'd0, 16'h0, 1'b0}) begin
            failures++;
            $display("FAIL single_release got=%b/%0d/%h/%b want=0/0/0000/0", grant_valid,
                     grant_id, grant_vec, preempt);
        end
        req = 16'h0003;
        tick();
        checks++;
        if (grant_valid !== 1'b0) begin
            failures++; $display("FAIL single_turn got=%b want=0", grant_valid);
        end
        tick();
        checks++;
        if ({grant_valid, grant_id} !== {1'b1, 4'd1}) begin
            failures++;
            $display("FAIL single_ptr got=%b/%0d want=1/1", grant_valid, grant_id);
        end
        req = 16'h0;
        tick(); tick(); tick();
    endtask

    task automatic test_rotation();
        logic [3:0]  exp_id;
        logic [15:0] exp_vec;
        do_reset();
        req = 16'hFFFF;
        for (int g = 0; g < 17; g++) begin
            exp_id  = 4'(g % 16);
            exp_vec = 16'h1 << exp_id;
            for (int c = 1; c <= MAX_HOLD; c++) begin
                tick();
                checks++;
                if ({grant_valid, grant_id} !== {1'b1, exp_id}) begin
                    failures++;
                    $display("FAIL rot_hold g=%0d c=%0d got=%b/%0d want=1/%0d", g, c,
                             grant_valid, grant_id, exp_id);
                end
                if (c == 1) begin
                    checks++;
                    if (grant_vec !== exp_vec) begin
                        failures++;
                        $display("FAIL rot_vec g=%0d got=%h want=%h", g, grant_vec, exp_vec);
                    end
                end
            end
            tick();
            checks++;
            if ({grant_valid, preempt} !== 2'b01) begin
                failures++;
                $display("FAIL rot_preempt g=%0d got=%b%b want=01", g, grant_valid, preempt);
            end
            tick();
            checks++;
            if ({grant_valid, preempt} !== 2'b00) begin
                failures++;
                $display("FAIL rot_gap g=%0d got=%b%b want=00", g, grant_valid, preempt);
            end
        end
        req = 16'h0;
        tick(); tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h0010;
        tick();
        checks++;
        if ({grant_valid, grant_id} !== {1'b1, 4'd4}) begin
            failures++; $display("FAIL wrap_first got=%b/%0d want=1/4", grant_valid, grant_id);
        end
        req = 16'h0;
        tick();
        req = 16'h0011;
        tick();
        tick();
        checks++;
        if ({grant_valid, grant_id} !== {1'b1, 4'd0}) begin
            failures++; $display("FAIL wrap_zero got=%b/%0d want=1/0", grant_valid, grant_id);
        end
        req = 16'h0010;
        tick(); tick(); tick();
        checks++;
        if ({grant_valid, grant_id} !== {1'b1, 4'd4}) begin
            failures++; $display("FAIL wrap_four got=%b/%0d want=1/4", grant_valid, grant_id);
        end
        req = 16'h0;
        tick(); tick(); tick();
    endtask

    task automatic test_release_timeout();
        do_reset();
        req = 16'h0004;
        for (int c = 1; c <= MAX_HOLD; c++) begin
            tick();
            checks++;
            if ({grant_valid, grant_id} !== {1'b1, 4'd2}) begin
                failures++;
                $display("FAIL rt_hold c=%0d got=%b/%0d want=1/2", c, grant_valid, grant_id);
            end
        end
        req = 16'h0;
        tick();
        checks++;
        if ({grant_valid, preempt, grant_vec} !== {2'b00, 16'h0}) begin
            failures++;
            $display("FAIL rt_same_cycle got=%b/%b/%h want=0/0/0000", grant_valid, preempt,
                     grant_vec);
        end
        tick(); tick();
    endtask

    task automatic test_enable();
        do_reset();
        req = 16'h0300;
        tick();
        checks++;
        if ({grant_valid, grant_id} !== {1'b1, 4'd8}) begin
            failures++; $display("FAIL en_first got=%b/%0d want=1/8", grant_valid, grant_id);
        end
        enable = 1'b0;
        tick();
        checks++;
        if ({grant_valid, grant_id} !== {1'b1, 4'd8}) begin
            failures++; $display("FAIL en_keep got=%b/%0d want=1/8", grant_valid, grant_id);
        end
        req = 16'h0200;
        tick();
        tick();
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b0) begin
                failures++; $display("FAIL en_blocked c=%0d got=%b want=0", c, grant_valid);
            end
        end
        enable = 1'b1;
        tick();
        checks++;
        if ({grant_valid, grant_id} !== {1'b1, 4'd9}) begin
            failures++; $display("FAIL en_resume got=%b/%0d want=1/9", grant_valid, grant_id);
        end
        req = 16'h0;
        tick(); tick(); tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 16'h0080;
        tick();
        checks++;
        if ({grant_valid, grant_id} !== {1'b1, 4'd7}) begin
            failures++; $display("FAIL ar_grant got=%b/%0d want=1/7", grant_valid, grant_id);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({grant_valid, grant_vec, grant_id} !== {1'b0, 16'h0, 4'd0}) begin
            failures++;
            $display("FAIL ar_clear got=%b/%h/%0d want=0/0000/0", grant_valid, grant_vec,
                     grant_id);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({grant_valid, grant_id} !== {1'b1, 4'd7}) begin
            failures++; $display("FAIL ar_regrant got=%b/%0d want=1/7", grant_valid, grant_id);
        end
        req = 16'h0;
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        logic [15:0] exp_vec;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 16'($urandom) & 16'($urandom);
            end
            enable = ($urandom_range(0, 7) != 0);
            tick();
            exp_vec = m_busy ? (16'h1 << m_owner) : 16'h0;
            checks += 5;
            if (grant_valid !== m_busy) begin
                failures++;
                $display("FAIL rnd_valid n=%0d got=%b want=%b", n, grant_valid, m_busy);
            end
            if (grant_vec !== exp_vec) begin
                failures++;
                $display("FAIL rnd_vec n=%0d got=%h want=%h", n, grant_vec, exp_vec);
            end
            if (grant_id !== 4'(m_last_id)) begin
                failures++;
                $display("FAIL rnd_id n=%0d got=%0d want=%0d", n, grant_id, m_last_id);
            end
            if (preempt !== m_pre) begin
                failures++;
                $display("FAIL rnd_preempt n=%0d got=%b want=%b", n, preempt, m_pre);
            end
            if ($countones(grant_vec) > 1) begin
                failures++;
                $display("FAIL rnd_onehot n=%0d got=%h want=onehot_or_zero", n, grant_vec);
            end
        end
        req = 16'h0;
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_release_timeout();
        test_enable();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
